// File: rtl/bcd_pkg.sv
// Shared constants for the BCD scan display: segment patterns,
// the "no digit" code and the scan phase enum.
package bcd_pkg;

  localparam logic [3:0] BCD_NONE = 4'hF;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    PH_BLANK,
    PH_SHOW
  } phase_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to 7-segment decode (seg[0]=a .. seg[6]=g).
// Ports: code (4-bit digit), seg (active-high segments).
module bcd_to_seg
  import bcd_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:  seg = SEG_0;
      4'd1:  seg = SEG_1;
      4'd2:  seg = SEG_2;
      4'd3:  seg = SEG_3;
      4'd4:  seg = SEG_4;
      4'd5:  seg = SEG_5;
      4'd6:  seg = SEG_6;
      4'd7:  seg = SEG_7;
      4'd8:  seg = SEG_8;
      4'd9:  seg = SEG_9;
      4'd10, 4'd11, 4'd12,
      4'd13, 4'd14: seg = SEG_DASH;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Multiplexed 7-segment scanner with frame-synchronous double buffer.
// Ports: CLK, RST (async high), LOAD/DIN in, LOAD_ACK, DIG, SEG, ERR out.
// Define BCD_LZB_EN to blank leading zeros (digit 0 always shown).
module bcd_seg_scan
  import bcd_pkg::*;
#(
  parameter int NDIG      = 4,
  parameter int PRESCALE  = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LOAD,
  input  logic [4*NDIG-1:0] DIN,
  output logic              LOAD_ACK,
  output logic [NDIG-1:0]   DIG,
  output logic [6:0]        SEG,
  output logic              ERR
);

  localparam int CMAX = (PRESCALE > BLANK_CYC) ? PRESCALE : BLANK_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int SW   = $clog2(NDIG);

  localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(NDIG - 1);

  phase_t                 phase, phase_nxt;
  logic [SW-1:0]          slot, slot_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   boundary;

  logic [NDIG-1:0][3:0]   disp, pend, disp_nxt;
  logic                   pend_vld;
  logic                   apply;
  logic                   err_nxt;

  logic [NDIG-1:0]        lzb;
  logic [3:0]             code;
  logic [6:0]             seg_dec;
  logic [NDIG-1:0]        dig_nxt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase <= PH_BLANK;
      slot  <= '0;
      cnt   <= '0;
    end else begin
      phase <= phase_nxt;
      slot  <= slot_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    phase_nxt = phase;
    slot_nxt  = slot;
    cnt_nxt   = cnt + 1'b1;
    boundary  = 1'b0;
    unique case (phase)
      PH_BLANK: begin
        if (cnt == BLANK_LAST) begin
          phase_nxt = PH_SHOW;
          cnt_nxt   = '0;
        end
      end
      PH_SHOW: begin
        if (cnt == SHOW_LAST) begin
          phase_nxt = PH_BLANK;
          cnt_nxt   = '0;
          boundary  = (slot == SLOT_LAST);
          slot_nxt  = boundary ? '0 : slot + 1'b1;
        end
      end
    endcase
  end

  // A LOAD on the boundary cycle bypasses the pending buffer.
  assign apply    = boundary & (LOAD | pend_vld);
  assign disp_nxt = LOAD ? DIN : pend;

  always_comb begin
    err_nxt = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (disp_nxt[i] >= 4'd10 && disp_nxt[i] != BCD_NONE)
        err_nxt = 1'b1;
    end
  end

`ifdef BCD_LZB_EN
  logic run;
  always_comb begin
    lzb = '0;
    run = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      if (run && disp[i] == 4'd0) lzb[i] = 1'b1;
      else run = 1'b0;
    end
  end
`else
  assign lzb = '0;
`endif

  // Outputs are registered from the next state so they line up
  // with the phase/slot registers.
  assign code    = lzb[slot_nxt] ? BCD_NONE : disp[slot_nxt];
  assign dig_nxt = {{(NDIG-1){1'b0}}, 1'b1} << slot_nxt;

  bcd_to_seg u_dec (
    .code (code),
    .seg  (seg_dec)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      disp     <= {NDIG{BCD_NONE}};
      pend     <= {NDIG{BCD_NONE}};
      pend_vld <= 1'b0;
      LOAD_ACK <= 1'b0;
      ERR      <= 1'b0;
      DIG      <= '0;
      SEG      <= '0;
    end else begin
      if (apply) begin
        disp     <= disp_nxt;
        pend_vld <= 1'b0;
        ERR      <= err_nxt;
      end else if (LOAD) begin
        pend     <= DIN;
        pend_vld <= 1'b1;
      end
      LOAD_ACK <= apply;
      DIG <= (phase_nxt == PH_SHOW) ? dig_nxt : '0;
      SEG <= (phase_nxt == PH_SHOW) ? seg_dec : 7'h00;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Self-checking bench for bcd_seg_scan (NDIG=4, PRESCALE=4, BLANK_CYC=1).
// Expected frames are queued on LOAD and compared after LOAD_ACK.
module tb_bcd_seg_scan;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        LOAD = 1'b0;
  logic [15:0] DIN = 16'h0;
  logic        LOAD_ACK;
  logic [3:0]  DIG;
  logic [6:0]  SEG;
  logic        ERR;

  bcd_seg_scan #(
    .NDIG      (4),
    .PRESCALE  (4),
    .BLANK_CYC (1)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .LOAD     (LOAD),
    .DIN      (DIN),
    .LOAD_ACK (LOAD_ACK),
    .DIG      (DIG),
    .SEG      (SEG),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0][6:0] segs;
    logic            err;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      4'd15: return 7'h00;
      default: return 7'h40;
    endcase
  endfunction

  function automatic exp_t model(input logic [15:0] d);
    exp_t e;
    bit lead;
    e.err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e.segs[i] = ref_seg(d[4*i +: 4]);
      if (d[4*i +: 4] >= 4'd10 && d[4*i +: 4] != 4'hF) e.err = 1'b1;
    end
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (lead && d[4*i +: 4] == 4'd0) begin
`ifdef BCD_LZB_EN
        e.segs[i] = 7'h00;
`endif
      end else begin
        lead = 1'b0;
      end
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input bit overwrite);
    if (overwrite && sb.size() > 0) sb.delete(sb.size() - 1);
    sb.push_back(model(d));
    DIN  = d;
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (LOAD_ACK === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Called on the first (blank) cycle of a frame; collects the frame.
  task automatic take_frame(output exp_t obs, output int acks,
                            output int shape);
    logic [3:0] ed;
    int s, p;
    obs   = '0;
    acks  = 0;
    shape = 0;
    obs.err = ERR;
    if (DIG !== 4'b0000 || SEG !== 7'h00) shape++;
    for (int k = 1; k < 20; k++) begin
      tick();
      s  = k / 5;
      p  = k % 5;
      ed = (p == 0) ? 4'b0000 : (4'b0001 << s);
      if (DIG !== ed) shape++;
      if (p == 0 && SEG !== 7'h00) shape++;
      if (p == 1) obs.segs[s] = SEG;
      else if (p > 1 && SEG !== obs.segs[s]) shape++;
      if (LOAD_ACK === 1'b1) acks++;
    end
  endtask

  task automatic test_reset();
    exp_t obs;
    int acks, shape, n;
    RST = 1'b0;
    #2 RST = 1'b1;
    repeat (3) tick();
    total++;
    if ({DIG, SEG, ERR, LOAD_ACK} !== 13'h0) begin
      bad++;
      $display("FAIL reset_outs got dig=%b seg=%h err=%b ack=%b want 0",
               DIG, SEG, ERR, LOAD_ACK);
    end
    RST = 1'b0;
    take_frame(obs, acks, shape);
    total++;
    if (shape != 0 || acks != 0) begin
      bad++;
      $display("FAIL reset_frame_shape got shape_err=%0d acks=%0d want 0/0",
               shape, acks);
    end
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL reset_blank got %h want %h", obs, exp_t'('0));
    end
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (DIG === 4'b0001) break;
    end
    total++;
    if (18 + n != 20) begin
      bad++;
      $display("FAIL frame_len got %0d want 20", 18 + n);
    end
  endtask

  task automatic run_load(input string name, input logic [15:0] d);
    exp_t obs, e;
    int acks, shape;
    bit ok;
    send(d, 1'b0);
    wait_ack(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_ack got none want pulse", name);
      return;
    end
    e = sb.pop_front();
    take_frame(obs, acks, shape);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL %s_frame got %h want %h", name, obs, e);
    end
    total++;
    if (shape != 0 || acks != 0) begin
      bad++;
      $display("FAIL %s_shape got shape_err=%0d acks=%0d want 0/0",
               name, shape, acks);
    end
  endtask

  task automatic test_load();
    run_load("load1234", 16'h1234);
  endtask

  task automatic test_err();
    run_load("err0a5f", 16'h0A5F);
  endtask

  task automatic test_overwrite();
    exp_t obs, e;
    int acks, shape;
    bit ok;
    tick();
    send(16'h1111, 1'b0);
    repeat (3) tick();
    send(16'h2222, 1'b1);
    wait_ack(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ovw_ack got none want pulse");
      return;
    end
    e = sb.pop_front();
    take_frame(obs, acks, shape);
    total++;
    if (obs !== e || acks != 0 || shape != 0) begin
      bad++;
      $display("FAIL ovw_frame got %h acks=%0d shape=%0d want %h/0/0",
               obs, acks, shape, e);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL ovw_queue got %0d want 0", sb.size());
    end
    send(16'h3333, 1'b0);
    total++;
    if (LOAD_ACK !== 1'b1) begin
      bad++;
      $display("FAIL bypass_ack got %b want 1", LOAD_ACK);
    end
    e = sb.pop_front();
    take_frame(obs, acks, shape);
    total++;
    if (obs !== e || acks != 0 || shape != 0) begin
      bad++;
      $display("FAIL bypass_frame got %h acks=%0d shape=%0d want %h/0/0",
               obs, acks, shape, e);
    end
  endtask

  task automatic test_reset_mid();
    exp_t obs;
    int acks, shape, n;
    tick();
    send(16'h5555, 1'b0);
    n = 0;
    while (DIG !== 4'b0100 && n < 30) begin
      tick();
      n++;
    end
    total++;
    if (DIG !== 4'b0100) begin
      bad++;
      $display("FAIL rstmid_reach got %b want 0100", DIG);
    end
    RST = 1'b1;
    #1;
    total++;
    if (DIG !== 4'b0000 || SEG !== 7'h00) begin
      bad++;
      $display("FAIL rstmid_async got dig=%b seg=%h want 0/00", DIG, SEG);
    end
    sb.delete();
    tick();
    tick();
    RST = 1'b0;
    total++;
    if (LOAD_ACK !== 1'b0 || ERR !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_rel got ack=%b err=%b want 0/0", LOAD_ACK, ERR);
    end
    take_frame(obs, acks, shape);
    total++;
    if (obs !== '0 || acks != 0 || shape != 0) begin
      bad++;
      $display("FAIL rstmid_blank got %h acks=%0d shape=%0d want 0/0/0",
               obs, acks, shape);
    end
    tick();
    total++;
    if (LOAD_ACK !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_noack got %b want 0", LOAD_ACK);
    end
  endtask

  task automatic test_lzb();
    run_load("lzb0050", 16'h0050);
  endtask

  initial begin
    test_reset();
    test_load();
    test_err();
    test_overwrite();
    test_reset_mid();
    test_lzb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
